cpumc_banked: RTL and testbench
===============================

# cpumc_banked

Parametrised CPU memory controller for the NES core with UxROM-style PRG bank switching, optional 8 KB work RAM and a registered request/response interface. It sits between the 6502 core and the on-chip block RAMs, replacing the fixed two-bank PRG layout with a configurable bank count. It also exposes a load mode so the host-side loader can fill all PRG banks before the CPU is released.

## Interface

Parameters:
- PRG_BANKS, 8, number of 16 KB PRG banks; power of two, 2..16.
- WRAM_EN, 1, 1 instantiates 8 KB work RAM at 0x6000–0x7FFF; 0 makes that range invalid.
- INVALID_DATA, 8'hCD, read data returned for unmapped addresses.

Ports (BW = log2(PRG_BANKS)):
- clk  in  1  system clock (50 MHz). One clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  1  access strobe; one request accepted per cycle when high.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  CPU address; sampled with req.
- din  in  8  write data; sampled with req.
- load_mode  in  1  1 = writes at 0x8000–0xFFFF go to PRG memory; 0 = they write the bank register.
- load_bank  in  BW  physical PRG bank targeted by load-mode writes.
- dout  out  8  read data, valid when rd_valid = 1; holds its value otherwise.
- rd_valid  out  1  one-cycle pulse: read response present on dout.
- invalid_req  out  1  one-cycle pulse: request accepted the previous cycle hit an unmapped range.
- bank_sel  out  BW  current switchable-bank register.

## Operation

- Address decode, applied to the sampled addr:
  - 0x0000–0x1FFF: 2 KB internal RAM, index addr[10:0]. Mirrored 4×.
  - 0x2000–0x5FFF: invalid, covering I/O regs and expansion ROM, which are owned by other blocks.
  - 0x6000–0x7FFF: work RAM, index addr[12:0], when WRAM_EN = 1; invalid otherwise.
  - 0x8000–0xBFFF: PRG physical address {bank_sel, addr[13:0]}.
  - 0xC000–0xFFFF: PRG physical address {PRG_BANKS-1, addr[13:0]}, the fixed last bank.
- PRG storage is one synchronous RAM of PRG_BANKS × 16 KB.
- Reads: every mapped read returns the memory byte. Invalid reads return INVALID_DATA with invalid_req = 1.
- Writes to RAM and WRAM: memory updated.
- Writes to 0x8000–0xFFFF with load_mode = 1: PRG written at {load_bank, addr[13:0]}. The fixed-bank mapping is ignored here; the physical bank is always load_bank.
- Writes to 0x8000–0xFFFF with load_mode = 0:
  - bank_sel ← din[BW-1:0]; upper bits are ignored, so the bank number wraps modulo PRG_BANKS.
  - PRG memory is not modified.
- Invalid writes: no state change, invalid_req = 1.
- Memory contents are not cleared by reset.

## Timing

- Reset (rst_n low at a clk edge):
  - dout = 8'h00, rd_valid = 0, invalid_req = 0, bank_sel = 0.
  - A request presented in a reset cycle is dropped: no memory write, no response.
- Latency is fixed at 1 cycle. A request accepted at edge N produces rd_valid / invalid_req / dout at edge N+1.
- Fully pipelined: back-to-back requests every cycle with no stalls. No ready signal is needed.
- bank_sel updates at edge N+1 for a bank write accepted at N. A read accepted at N+1 uses the new bank.
- Read-after-write to the same address in consecutive cycles returns the newly written data. The RAM write at edge N precedes the read at N+1.
- load_mode and load_bank are sampled with req. Changing them between requests is legal.
- rd_valid and invalid_req are both 1 for an invalid read. For writes, rd_valid = 0.
- When req = 0, the next cycle has rd_valid = 0, invalid_req = 0, and dout unchanged.

## Test plan

- Reset: hold rst_n low 2 cycles with req = 1 wr = 1 addr = 0x0000 din = 0x55. Required response: all outputs at reset values; a subsequent read of 0x0000 does not return 0x55 unless written after reset.
- RAM mirror: write 0x0005 = 0x3C, then read 0x0805, 0x1005 and 0x1805 back-to-back. Required response: 0x3C on each, rd_valid high 3 consecutive cycles, invalid_req = 0.
- Bank switching (PRG_BANKS = 8):
  - Load phase, load_mode = 1: write bank 2 offset 0x0010 = 0xA5 and bank 7 offset 0x0010 = 0x5A.
  - Run phase, load_mode = 0: write 0x8000 din = 0x0A. Required: bank_sel = 2 (wrap).
  - Read 0x8010 next cycle → 0xA5. Read 0xC010 → 0x5A.
- Invalid ranges: read 0x2002, 0x4020 and (with WRAM_EN = 0) 0x6000. Required: dout = 0xCD, rd_valid = 1, invalid_req = 1 each. Writing 0x4020 gives invalid_req = 1 and no memory change.
- WRAM (WRAM_EN = 1): write 0x7FFF = 0x99 and read it back on the next cycle. Required: dout = 0x99 one cycle after the read request.
- Reset mid-operation: set bank_sel = 3, then assert rst_n low during a read of 0x8000. Required: no rd_valid for that read, and bank_sel = 0 afterwards.

Source files
------------

// File: rtl/cpumc_banked.sv
// CPU-side memory controller: 2 KB RAM, optional 8 KB WRAM and UxROM-banked PRG
// behind a one-cycle registered request/response port, with a PRG load mode.
module cpumc_banked #(
   parameter int         PRG_BANKS    = 8,
   parameter bit         WRAM_EN      = 1'b1,
   parameter logic [7:0] INVALID_DATA = 8'hCD,
   localparam int        BW           = $clog2(PRG_BANKS)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          req_i,
   input  logic          wr_i,
   input  logic [15:0]   addr_i,
   input  logic [7:0]    din_i,
   input  logic          load_mode_i,
   input  logic [BW-1:0] load_bank_i,
   output logic [7:0]    dout_o,
   output logic          rd_valid_o,
   output logic          invalid_req_o,
   output logic [BW-1:0] bank_sel_o
);

   localparam int            PAW       = BW + 14;
   localparam logic [BW-1:0] LAST_BANK = BW'(PRG_BANKS - 1);

   localparam logic [2:0] SEL_ZERO = 3'd0;
   localparam logic [2:0] SEL_RAM  = 3'd1;
   localparam logic [2:0] SEL_WRAM = 3'd2;
   localparam logic [2:0] SEL_PRG  = 3'd3;
   localparam logic [2:0] SEL_INV  = 3'd4;

   logic          acc;
   logic          hit_ram, hit_wram, hit_prg, hit_inv;
   logic [BW-1:0] prg_bank;
   logic [PAW-1:0] prg_addr;

   logic [BW-1:0] bank_sel_q, bank_sel_d;
   logic          rd_valid_q, invalid_q;
   logic [2:0]    sel_q, sel_d;
   logic [7:0]    ram_rd_q, prg_rd_q, wram_rd;

   logic [7:0] ram_mem [2048];
   logic [7:0] prg_mem [PRG_BANKS*16384];

   // A request seen while reset is held is dropped entirely.
   assign acc      = req_i & rst_n_i;
   assign hit_ram  = (addr_i[15:13] == 3'b000);
   assign hit_wram = (addr_i[15:13] == 3'b011) && WRAM_EN;
   assign hit_prg  = addr_i[15];
   assign hit_inv  = ~(hit_ram | hit_wram | hit_prg);

   // Load-mode writes always target load_bank, even in the fixed upper window.
   always_comb begin
      prg_bank = bank_sel_q;
      if (wr_i && load_mode_i) prg_bank = load_bank_i;
      else if (addr_i[14])     prg_bank = LAST_BANK;
   end
   assign prg_addr = {prg_bank, addr_i[13:0]};

   always_ff @(posedge clk_i) begin
      if (acc && hit_ram) begin
         if (wr_i) ram_mem[addr_i[10:0]] <= din_i;
         else      ram_rd_q <= ram_mem[addr_i[10:0]];
      end
   end

   always_ff @(posedge clk_i) begin
      if (acc && hit_prg) begin
         if (wr_i && load_mode_i) prg_mem[prg_addr] <= din_i;
         else if (!wr_i)          prg_rd_q <= prg_mem[prg_addr];
      end
   end

   generate
      if (WRAM_EN) begin : g_wram
         logic [7:0] wram_mem [8192];
         logic [7:0] wram_rd_q;
         always_ff @(posedge clk_i) begin
            if (acc && hit_wram) begin
               if (wr_i) wram_mem[addr_i[12:0]] <= din_i;
               else      wram_rd_q <= wram_mem[addr_i[12:0]];
            end
         end
         assign wram_rd = wram_rd_q;
      end else begin : g_no_wram
         assign wram_rd = 8'h00;
      end
   endgenerate

   always_comb begin
      bank_sel_d = bank_sel_q;
      if (acc && hit_prg && wr_i && !load_mode_i) bank_sel_d = din_i[BW-1:0];
   end

   // sel_q only moves on reads, so dout holds across writes and idle cycles.
   always_comb begin
      sel_d = sel_q;
      if (acc && !wr_i) begin
         if (hit_inv)       sel_d = SEL_INV;
         else if (hit_ram)  sel_d = SEL_RAM;
         else if (hit_wram) sel_d = SEL_WRAM;
         else               sel_d = SEL_PRG;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         bank_sel_q <= '0;
         rd_valid_q <= 1'b0;
         invalid_q  <= 1'b0;
         sel_q      <= SEL_ZERO;
      end else begin
         bank_sel_q <= bank_sel_d;
         rd_valid_q <= acc & ~wr_i;
         invalid_q  <= acc & hit_inv;
         sel_q      <= sel_d;
      end
   end

   always_comb begin
      dout_o = 8'h00;
      case (sel_q)
         SEL_RAM:  dout_o = ram_rd_q;
         SEL_WRAM: dout_o = wram_rd;
         SEL_PRG:  dout_o = prg_rd_q;
         SEL_INV:  dout_o = INVALID_DATA;
         default:  dout_o = 8'h00;
      endcase
   end

   assign rd_valid_o    = rd_valid_q;
   assign invalid_req_o = invalid_q;
   assign bank_sel_o    = bank_sel_q;

endmodule

// File: tb/tb_cpumc_banked.sv
// Bench for cpumc_banked: directed vector table, hand sequences for reset corners,
// then random traffic against an address-map reference model.
module tb_cpumc_banked;

   localparam int NB = 8;

   logic        clk, rst_n, req, wr, lm;
   logic [15:0] addr;
   logic [7:0]  din;
   logic [2:0]  lb;
   logic [7:0]  dout, nw_dout;
   logic        rv, inv, nw_rv, nw_inv;
   logic [2:0]  bank, nw_bank;

   cpumc_banked #(.PRG_BANKS(NB), .WRAM_EN(1'b1), .INVALID_DATA(8'hCD)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .wr_i(wr), .addr_i(addr), .din_i(din),
      .load_mode_i(lm), .load_bank_i(lb), .dout_o(dout), .rd_valid_o(rv),
      .invalid_req_o(inv), .bank_sel_o(bank));

   cpumc_banked #(.PRG_BANKS(NB), .WRAM_EN(1'b0), .INVALID_DATA(8'hCD)) u_nowram (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .wr_i(wr), .addr_i(addr), .din_i(din),
      .load_mode_i(lm), .load_bank_i(lb), .dout_o(nw_dout), .rd_valid_o(nw_rv),
      .invalid_req_o(nw_inv), .bank_sel_o(nw_bank));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: storage keyed by physical location, outputs from the address map.
   logic [7:0] mem [int];
   int         m_bank = 0;
   logic       m_v, m_i, m_dk;
   logic [7:0] m_d = 8'h00;

   task automatic model_step();
      int key;
      logic known;
      if (!rst_n) begin
         m_v = 0; m_i = 0; m_d = 8'h00; m_dk = 1; m_bank = 0;
         return;
      end
      m_v = req && !wr;
      m_i = 0;
      if (!req) return;
      key = -1;
      if (addr < 16'h2000) key = addr % 2048;
      else if (addr >= 16'h6000 && addr < 16'h8000) key = 32'h10000 + (addr - 16'h6000);
      else if (addr >= 16'h8000) begin
         if (wr && lm)            key = 32'h100000 + lb * 16384 + addr % 16384;
         else if (addr >= 16'hC000) key = 32'h100000 + (NB - 1) * 16384 + addr % 16384;
         else                     key = 32'h100000 + m_bank * 16384 + addr % 16384;
      end
      if (key < 0) begin
         m_i = 1;
         if (!wr) begin m_d = 8'hCD; m_dk = 1; end
      end else if (wr) begin
         if (addr >= 16'h8000 && !lm) m_bank = din % NB;
         else mem[key] = din;
      end else begin
         known = mem.exists(key);
         m_dk = known;
         if (known) m_d = mem[key];
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic l, input logic [2:0] b);
      req = r; wr = w; addr = a; din = d; lm = l; lb = b;
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic r, w; logic [15:0] a; logic [7:0] d; logic l; logic [2:0] b;
      logic ev, ei, cd; logic [7:0] ed; logic cb; logic [2:0] eb;
   } vec_t;
   vec_t vq[$];

   task automatic addv(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic l, input logic [2:0] b, input logic ev, input logic ei,
                       input logic cd, input logic [7:0] ed, input logic cb, input logic [2:0] eb);
      vec_t v;
      v.r = r; v.w = w; v.a = a; v.d = d; v.l = l; v.b = b;
      v.ev = ev; v.ei = ei; v.cd = cd; v.ed = ed; v.cb = cb; v.eb = eb;
      vq.push_back(v);
   endtask

   initial begin
      //   r  w  addr      din    lm b   ev ei cd dout   cb bank
      addv(1, 1, 16'h0005, 8'h3C, 0, 0,  0, 0, 0, 8'h00, 0, 0);
      addv(1, 0, 16'h0805, 8'h00, 0, 0,  1, 0, 1, 8'h3C, 0, 0);
      addv(1, 0, 16'h1005, 8'h00, 0, 0,  1, 0, 1, 8'h3C, 0, 0);
      addv(1, 0, 16'h1805, 8'h00, 0, 0,  1, 0, 1, 8'h3C, 0, 0);
      addv(1, 1, 16'h0020, 8'h11, 0, 0,  0, 0, 0, 8'h00, 0, 0);
      addv(1, 1, 16'h6020, 8'h22, 0, 0,  0, 0, 0, 8'h00, 0, 0);
      addv(1, 1, 16'h8010, 8'hA5, 1, 2,  0, 0, 0, 8'h00, 1, 0);
      addv(1, 1, 16'h8010, 8'h5A, 1, 7,  0, 0, 0, 8'h00, 1, 0);
      addv(1, 1, 16'h8000, 8'h0A, 0, 0,  0, 0, 0, 8'h00, 1, 2);
      addv(1, 0, 16'h8010, 8'h00, 0, 0,  1, 0, 1, 8'hA5, 1, 2);
      addv(1, 0, 16'hC010, 8'h00, 0, 0,  1, 0, 1, 8'h5A, 1, 2);
      addv(1, 0, 16'h2002, 8'h00, 0, 0,  1, 1, 1, 8'hCD, 0, 0);
      addv(1, 0, 16'h4020, 8'h00, 0, 0,  1, 1, 1, 8'hCD, 0, 0);
      addv(1, 1, 16'h4020, 8'h55, 0, 0,  0, 1, 1, 8'hCD, 0, 0);
      addv(1, 0, 16'h0020, 8'h00, 0, 0,  1, 0, 1, 8'h11, 0, 0);
      addv(1, 0, 16'h6020, 8'h00, 0, 0,  1, 0, 1, 8'h22, 0, 0);
      addv(1, 1, 16'h7FFF, 8'h99, 0, 0,  0, 0, 0, 8'h00, 0, 0);
      addv(1, 0, 16'h7FFF, 8'h00, 0, 0,  1, 0, 1, 8'h99, 0, 0);
      addv(0, 0, 16'h7FFF, 8'h00, 0, 0,  0, 0, 1, 8'h99, 0, 0);
      addv(1, 1, 16'hC020, 8'h77, 1, 0,  0, 0, 0, 8'h00, 1, 2);
      addv(1, 1, 16'h8000, 8'hF8, 0, 0,  0, 0, 0, 8'h00, 1, 0);
      addv(1, 0, 16'h8020, 8'h00, 0, 0,  1, 0, 1, 8'h77, 1, 0);

      // Reset held two cycles with a write pending: it must be dropped.
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc(1, 1, 16'h0000, 8'h55, 0, 0);
         chk($sformatf("rst%0d dout", i), dout, 8'h00);
         chk($sformatf("rst%0d rd_valid", i), {7'd0, rv}, 8'h00);
         chk($sformatf("rst%0d invalid", i), {7'd0, inv}, 8'h00);
         chk($sformatf("rst%0d bank", i), {5'd0, bank}, 8'h00);
      end
      rst_n = 1'b1;
      cyc(1, 0, 16'h0000, 8'h00, 0, 0);
      chk("post-rst rd_valid", {7'd0, rv}, 8'h01);
      tests++;
      if (dout === 8'h55) begin
         fails++;
         $display("FAIL post-rst read 0x0000: got %h required not 55", dout);
      end

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].r, vq[i].w, vq[i].a, vq[i].d, vq[i].l, vq[i].b);
         chk($sformatf("vec%0d rd_valid", i), {7'd0, rv}, {7'd0, vq[i].ev});
         chk($sformatf("vec%0d invalid", i), {7'd0, inv}, {7'd0, vq[i].ei});
         if (vq[i].cd) chk($sformatf("vec%0d dout", i), dout, vq[i].ed);
         if (vq[i].cb) chk($sformatf("vec%0d bank", i), {5'd0, bank}, {5'd0, vq[i].eb});
      end

      // 0x6000 is invalid only on the instance without work RAM.
      cyc(1, 0, 16'h6000, 8'h00, 0, 0);
      chk("nowram dout", nw_dout, 8'hCD);
      chk("nowram rd_valid", {7'd0, nw_rv}, 8'h01);
      chk("nowram invalid", {7'd0, nw_inv}, 8'h01);
      chk("wram 6000 invalid", {7'd0, inv}, 8'h00);

      // Reset during a PRG read: no response, bank register cleared.
      cyc(1, 1, 16'h8000, 8'h03, 0, 0);
      chk("midrst bank set", {5'd0, bank}, 8'h03);
      rst_n = 1'b0;
      cyc(1, 0, 16'h8000, 8'h00, 0, 0);
      chk("midrst rd_valid", {7'd0, rv}, 8'h00);
      chk("midrst bank", {5'd0, bank}, 8'h00);
      chk("midrst dout", dout, 8'h00);
      rst_n = 1'b1;

      for (int n = 0; n < 600; n++) begin
         logic [15:0] a;
         logic        r, w, l;
         case ($urandom % 4)
            0: a = 16'(($urandom % 4) * 16'h0800 + ($urandom % 8));
            1: a = 16'(16'h6000 + ($urandom % 8));
            2: a = 16'(16'h8000 + ($urandom % 2) * 16'h4000 + ($urandom % 8));
            default: a = 16'(16'h2000 + ($urandom % 16'h4000));
         endcase
         r = ($urandom % 5) != 0;
         w = ($urandom % 2) != 0;
         l = ($urandom % 3) != 0;
         cyc(r, w, a, 8'($urandom), l, 3'($urandom));
         chk($sformatf("rnd%0d rd_valid", n), {7'd0, rv}, {7'd0, m_v});
         chk($sformatf("rnd%0d invalid", n), {7'd0, inv}, {7'd0, m_i});
         chk($sformatf("rnd%0d bank", n), {5'd0, bank}, 8'(m_bank));
         if (m_dk) chk($sformatf("rnd%0d dout", n), dout, m_d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
